// File: rtl/feeder_pkg.sv
// Shared types and sizing helpers for the systolic feeder slice.
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DONE     = 2'd3
    } feeder_state_e;

    localparam int MAT_M_DEF = 3;
    localparam int MAT_N_DEF = 3;
    localparam int MAT_L_DEF = 3;

    // Index width for a buffer of the given depth; never below one bit.
    function automatic int feeder_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int A_DEPTH_DEF = MAT_M_DEF * MAT_N_DEF;
    localparam int B_DEPTH_DEF = MAT_N_DEF * MAT_L_DEF;

endpackage

// File: rtl/feeder_bank.sv
// Operand register file: one write port, parallel read of SLICES elements
// located at rd_base_i + s*STRIDE (a column of A or a row of B).
module feeder_bank
    import feeder_pkg::*;
#(
    parameter int W      = 8,
    parameter int DEPTH  = A_DEPTH_DEF,
    parameter int ADDR_W = 10,
    parameter int SLICES = 3,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [W-1:0]          wr_data_i,
    input  logic [ADDR_W-1:0]     rd_base_i,
    output logic [SLICES*W-1:0]   rd_data_o
);

    localparam int IDX_W = feeder_idx_w(DEPTH);

    logic [W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_idx;

    // Out-of-range addresses are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i < ADDR_W'(DEPTH))) begin
            mem_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_idx    = '0;
        for (int s = 0; s < SLICES; s++) begin
            rd_idx = rd_base_i + ADDR_W'(s * STRIDE);
            if (rd_idx < ADDR_W'(DEPTH)) begin
                rd_data_o[s*W +: W] = mem_q[rd_idx[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Streams A columns / B rows into the systolic array, one beat per cycle.
// Optional FEEDER_DOUBLE_BUF_EN: ping-pong operand banks swapped on start.
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int MAT_M   = MAT_M_DEF,
    parameter int MAT_N   = MAT_N_DEF,
    parameter int MAT_L   = MAT_L_DEF,
    parameter int ADDR_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_wr_en,
    input  logic [ADDR_W-1:0]        a_wr_addr,
    input  logic [WIDTH_A-1:0]       a_wr_data,
    input  logic                     b_wr_en,
    input  logic [ADDR_W-1:0]        b_wr_addr,
    input  logic [WIDTH_B-1:0]       b_wr_data,
    input  logic                     start,
    input  logic                     arr_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     valid_left,
    output logic                     valid_up,
    output logic [MAT_M*WIDTH_A-1:0] left,
    output logic [MAT_L*WIDTH_B-1:0] up
);

    localparam int A_DEPTH = MAT_M * MAT_N;
    localparam int B_DEPTH = MAT_N * MAT_L;
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MAT_N - 1);

    feeder_state_e              state_q;
    logic [ADDR_W-1:0]          k_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       vld_q;
    logic [MAT_M*WIDTH_A-1:0]   left_q;
    logic [MAT_L*WIDTH_B-1:0]   up_q;

    logic                       start_acc;
    logic [ADDR_W-1:0]          a_base;
    logic [ADDR_W-1:0]          b_base;
    logic [MAT_M*WIDTH_A-1:0]   a_rd;
    logic [MAT_L*WIDTH_B-1:0]   b_rd;

    assign start_acc = start && (state_q == ST_IDLE);
    assign a_base    = k_q;
    assign b_base    = ADDR_W'(k_q * MAT_L);

`ifdef FEEDER_DOUBLE_BUF_EN
    // sel_q names the fill bank; the other bank is the one being streamed.
    logic                     sel_q;
    logic [MAT_M*WIDTH_A-1:0] a_rd0, a_rd1;
    logic [MAT_L*WIDTH_B-1:0] b_rd0, b_rd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q <= 1'b0;
        end else if (start_acc) begin
            sel_q <= ~sel_q;
        end
    end

    feeder_bank #(.W(WIDTH_A), .DEPTH(A_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_M), .STRIDE(MAT_N)) u_a_bank0 (
        .clk(clk), .wr_en_i(a_wr_en && !sel_q), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .rd_base_i(a_base), .rd_data_o(a_rd0));
    feeder_bank #(.W(WIDTH_A), .DEPTH(A_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_M), .STRIDE(MAT_N)) u_a_bank1 (
        .clk(clk), .wr_en_i(a_wr_en && sel_q), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .rd_base_i(a_base), .rd_data_o(a_rd1));
    feeder_bank #(.W(WIDTH_B), .DEPTH(B_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_L), .STRIDE(1)) u_b_bank0 (
        .clk(clk), .wr_en_i(b_wr_en && !sel_q), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_base_i(b_base), .rd_data_o(b_rd0));
    feeder_bank #(.W(WIDTH_B), .DEPTH(B_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_L), .STRIDE(1)) u_b_bank1 (
        .clk(clk), .wr_en_i(b_wr_en && sel_q), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_base_i(b_base), .rd_data_o(b_rd1));

    assign a_rd = sel_q ? a_rd0 : a_rd1;
    assign b_rd = sel_q ? b_rd0 : b_rd1;
`else
    feeder_bank #(.W(WIDTH_A), .DEPTH(A_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_M), .STRIDE(MAT_N)) u_a_bank (
        .clk(clk), .wr_en_i(a_wr_en && !busy_q), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .rd_base_i(a_base), .rd_data_o(a_rd));
    feeder_bank #(.W(WIDTH_B), .DEPTH(B_DEPTH), .ADDR_W(ADDR_W), .SLICES(MAT_L), .STRIDE(1)) u_b_bank (
        .clk(clk), .wr_en_i(b_wr_en && !busy_q), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_base_i(b_base), .rd_data_o(b_rd));
`endif

    // k_q always indexes the beat to be registered on the next transfer edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            left_q  <= '0;
            up_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_q <= ST_WAIT_RDY;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (arr_ready) begin
                        vld_q   <= 1'b1;
                        left_q  <= a_rd;
                        up_q    <= b_rd;
                        k_q     <= k_q + 1'b1;
                        state_q <= (k_q == LAST_K) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    vld_q  <= 1'b1;
                    left_q <= a_rd;
                    up_q   <= b_rd;
                    k_q    <= k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    vld_q   <= 1'b0;
                    left_q  <= '0;
                    up_q    <= '0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    k_q     <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign valid_left = vld_q;
    assign valid_up   = vld_q;
    assign left       = left_q;
    assign up         = up_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: matrix-level reference model, randomized loads.
module tb_systolic_feeder;

    localparam int M = 3, N = 3, L = 3, W = 8, AW = 10;
`ifdef FEEDER_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a_wr_en = 1'b0, b_wr_en = 1'b0, start = 1'b0, arr_ready = 1'b0;
    logic [AW-1:0] a_wr_addr = '0, b_wr_addr = '0;
    logic [W-1:0]  a_wr_data = '0, b_wr_data = '0;
    logic busy, done, valid_left, valid_up;
    logic [M*W-1:0] left;
    logic [L*W-1:0] up;

    systolic_feeder dut (
        .clk(clk), .rst(rst),
        .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .start(start), .arr_ready(arr_ready),
        .busy(busy), .done(done), .valid_left(valid_left), .valid_up(valid_up),
        .left(left), .up(up)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [23:0] l;
        logic [23:0] u;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    bit          m_busy = 1'b0;
    int          fsel = 0;
    logic [7:0]  ma [2][M*N];
    logic [7:0]  mb [2][N*L];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: matrices A (MxN) and B (NxL) per bank.
    function automatic void m_wr(input bit is_b, input int addr, input logic [7:0] d);
        if (DBL || !m_busy) begin
            if (!is_b && addr < M*N) ma[fsel][addr] = d;
            if (is_b && addr < N*L)  mb[fsel][addr] = d;
        end
    endfunction

    function automatic void m_start();
        int   rb;
        exp_t e;
        rb = fsel;
        if (DBL) fsel = 1 - fsel;
        for (int k = 0; k < N; k++) begin
            e.is_done = 1'b0;
            e.l = '0;
            e.u = '0;
            for (int i = 0; i < M; i++) e.l[i*8 +: 8] = ma[rb][i*N + k];
            for (int j = 0; j < L; j++) e.u[j*8 +: 8] = mb[rb][k*L + j];
            sb.push_back(e);
        end
        e.is_done = 1'b1;
        e.l = '0;
        e.u = '0;
        sb.push_back(e);
        m_busy = 1'b1;
    endfunction

    task automatic step(input bit ae, input int aa, input logic [7:0] ad,
                        input bit be, input int ba, input logic [7:0] bd, input bit st);
        a_wr_en = ae; a_wr_addr = AW'(aa); a_wr_data = ad;
        b_wr_en = be; b_wr_addr = AW'(ba); b_wr_data = bd;
        start = st;
        if (ae) m_wr(1'b0, aa, ad);
        if (be) m_wr(1'b1, ba, bd);
        if (st && !m_busy) m_start();
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic load_all_rand();
        for (int x = 0; x < 9; x++) step(1'b1, x, 8'($urandom), 1'b1, x, 8'($urandom), 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 60) begin
            tick();
            n++;
        end
        if (m_busy) begin
            chk("idle_timeout", 64'(n), 64'(0));
            sb.delete();
            m_busy = 1'b0;
        end
    endtask

    task automatic run_stream(input int dly, input bit poke, input bit wrbusy, input bit wstart);
        int         wa;
        logic [7:0] wd;
        wa = $urandom_range(0, 8);
        wd = 8'($urandom);
        arr_ready = (dly == 0);
        step(wstart, wa, wd, 1'b0, 0, 8'h0, 1'b1);
        for (int i = 0; i < dly; i++) begin
            chk("wait_busy", 64'(busy), 64'(1));
            chk("wait_vld", 64'(valid_left), 64'(0));
            tick();
        end
        arr_ready = 1'b1;
        chk("pre_vld", 64'(valid_left), 64'(0));
        tick();
        chk("first_vld", 64'(valid_left), 64'(1));
        arr_ready = 1'($urandom_range(0, 1));
        wa = $urandom_range(0, 8);
        wd = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            if (i == 0 && (poke || wrbusy)) step(wrbusy, wa, wd, 1'b0, 0, 8'h0, poke);
            else tick();
        end
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_fall", 64'(busy), 64'(0));
        tick();
        chk("done_clear", 64'(done), 64'(0));
        arr_ready = 1'b1;
        wait_idle();
    endtask

    // Monitor: pops an expected item whenever the DUT presents a beat or done.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("vld_equal", 64'(valid_up), 64'(valid_left));
            if (!valid_left) begin
                chk("idle_left", 64'(left), 64'(0));
                chk("idle_up", 64'(up), 64'(0));
            end
            if (valid_left || done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {62'(0), valid_left, done}, 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("kind", 64'(done), 64'(e.is_done));
                    if (e.is_done) begin
                        chk("done_busy", 64'(busy), 64'(0));
                        m_busy = 1'b0;
                    end else begin
                        chk("left", 64'(left), 64'(e.l));
                        chk("up", 64'(up), 64'(e.u));
                        chk("beat_busy", 64'(busy), 64'(1));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_vleft", 64'(valid_left), 64'(0));
        chk("rst_vup", 64'(valid_up), 64'(0));
        chk("rst_left", 64'(left), 64'(0));
        chk("rst_up", 64'(up), 64'(0));
        rst = 1'b1;
        mon_en = 1'b1;
        arr_ready = 1'b1;

        // Populate every bank so no undefined contents ever reach the outputs.
        load_all_rand();
        run_stream(0, 1'b0, 1'b0, 1'b0);
        load_all_rand();

        // A = 1..9 row-major, B = identity.
        for (int x = 0; x < 9; x++)
            step(1'b1, x, 8'(x + 1), 1'b1, x, ((x % 4) == 0) ? 8'd1 : 8'd0, 1'b0);
        run_stream(0, 1'b0, 1'b0, 1'b0);

        run_stream(5, 1'b0, 1'b0, 1'b0);

        step(1'b1, 9, 8'hEE, 1'b1, 9, 8'hEE, 1'b0);
        step(1'b1, 1023, 8'hDD, 1'b1, 12, 8'hDD, 1'b0);
        run_stream(0, 1'b0, 1'b0, 1'b0);

        run_stream(0, 1'b0, 1'b1, 1'b0);
        run_stream(0, 1'b0, 1'b0, 1'b0);

        run_stream(0, 1'b0, 1'b0, 1'b1);

        // Abort during beat 1.
        arr_ready = 1'b1;
        step(1'b0, 0, 8'h0, 1'b0, 0, 8'h0, 1'b1);
        tick();
        tick();
        chk("abort_beat1", 64'(valid_left), 64'(1));
        rst = 1'b0;
        tick();
        sb.delete();
        m_busy = 1'b0;
        fsel = 0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_vld", 64'(valid_left), 64'(0));
        chk("abort_left", 64'(left), 64'(0));
        chk("abort_up", 64'(up), 64'(0));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
        end
        run_stream(0, 1'b0, 1'b0, 1'b0);

        run_stream(0, 1'b1, 1'b0, 1'b0);

        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++)
                step(1'($urandom_range(0, 1)), $urandom_range(0, 11), 8'($urandom),
                     1'($urandom_range(0, 1)), $urandom_range(0, 11), 8'($urandom), 1'b0);
            run_stream($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        if (DBL) begin
            for (int x = 0; x < 9; x++)
                step(1'b1, x, 8'($urandom), 1'b1, x, ((x % 4) == 0) ? 8'd1 : 8'd0, 1'b0);
            arr_ready = 1'b1;
            step(1'b0, 0, 8'h0, 1'b0, 0, 8'h0, 1'b1);
            for (int x = 0; x < 9; x++)
                step(1'b1, x, 8'($urandom), 1'b1, x, ((x % 4) == 0) ? 8'd2 : 8'd0, 1'b0);
            wait_idle();
            run_stream(0, 1'b0, 1'b0, 1'b0);
        end

        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic matrix multiplier.
- Holds operand matrices A (M x N) and B (N x L), loaded through simple write ports.
- On start, waits for the array's ready, then streams N beats to the array. Beat k carries:
  - column k of A on left, with valid_left;
  - row k of B on up, with valid_up.
- Pulses done when the last beat has been issued.

Parameters:
- WIDTH_A, 8, bit width of one A element (matches array WIDTH_left)
- WIDTH_B, 8, bit width of one B element (matches array WIDTH_up)
- MAT_M, 3, rows of A / output rows
- MAT_N, 3, shared inner dimension = number of streamed beats
- MAT_L, 3, columns of B / output columns
- ADDR_W, 10, width of write addresses and beat counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- a_wr_en  input  1  write strobe for A buffer
- a_wr_addr  input  ADDR_W  A element index i*MAT_N+k
- a_wr_data  input  WIDTH_A  A element value
- b_wr_en  input  1  write strobe for B buffer
- b_wr_addr  input  ADDR_W  B element index k*MAT_L+j
- b_wr_data  input  WIDTH_B  B element value
- start  input  1  one-cycle request to stream current buffers
- arr_ready  input  1  ready from multiplier array
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after last beat
- valid_left  output  1  left vector valid
- valid_up  output  1  up vector valid
- left  output  MAT_M*WIDTH_A  slice i = A[i][k]
- up  output  MAT_L*WIDTH_B  slice j = B[k][j]

Behaviour:
- Reset: rst sampled low on a clk edge forces:
  - state IDLE, beat counter 0;
  - busy, done, valid_left, valid_up = 0;
  - left, up = 0.
- Buffer contents are not reset. Reset mid-stream aborts immediately, with no done pulse.
- All outputs are registered.
- States:
  - IDLE: start=1 -> WAIT_RDY, busy<=1.
  - WAIT_RDY: arr_ready=1 -> STREAM, k<=0, and the beat-0 data/valids are registered the same edge. valid_left/valid_up are therefore high on the cycle after arr_ready is sampled high.
  - STREAM: each cycle present beat k, both valids 1, k<=k+1. On issuing k=MAT_N-1 -> DONE.
  - DONE: valids<=0, left/up<=0, done<=1 for one cycle, busy<=0, -> IDLE.
- Beat timing:
  - Exactly MAT_N consecutive beats; valids are never deasserted mid-stream.
  - arr_ready is ignored after leaving WAIT_RDY, because the array drops ready after accepting.
- valid_left and valid_up are always equal.
- Outside STREAM, left/up are driven 0.
- Writes:
  - Accepted only when an address is in range (A < MAT_M*MAT_N, B < MAT_N*MAT_L); out-of-range writes are dropped.
  - a and b writes in the same cycle are independent.
  - Writes while busy=1 are ignored in single-buffer mode.
- start while busy=1 is ignored.
- start and a write in the same IDLE cycle: the write lands first, so the stream uses the new value.

Optional Feature:
- FEEDER_DOUBLE_BUF_EN defined:
  - ping-pong banks for A and B;
  - writes always target the fill bank and are accepted regardless of busy;
  - an accepted start swaps banks, so streaming reads the just-filled bank.
- Undefined: a single bank, with writes ignored while busy.

Decomposition:
- Package feeder_pkg:
  - state encoding (IDLE=0, WAIT_RDY=1, STREAM=2, DONE=3);
  - a clog2-based helper for buffer depth;
  - A/B depth constants derived from MAT_*.
- Sub-module feeder_bank: parameterised register file with one write port and a full-width parallel read of one column/row slice. It is instantiated for A and B, twice each under FEEDER_DOUBLE_BUF_EN.

Test Plan:
- Load A=[[1,2,3],[4,5,6],[7,8,9]], B=identity; start with arr_ready=1 -> valids high 1 cycle after WAIT_RDY. Three beats:
  - left = {7,4,1}/{8,5,2}/{9,6,3} (slice 0 = row 0);
  - up = {0,0,1}/{0,1,0}/{1,0,0};
  - done one cycle after beat 2, busy falls with done.
- Hold arr_ready=0 for 5 cycles after start -> FSM stays in WAIT_RDY, valids 0, busy 1; raise arr_ready -> stream begins next cycle.
- Write a_wr_addr=9 (out of range), then stream -> A contents unchanged. Write during busy -> ignored; rerun shows old data (single-buffer build).
- Assert rst=0 during beat 1 -> next cycle all outputs 0, state IDLE, no done. A new start streams the full 3 beats.
- start pulsed while busy -> no second stream, and exactly one done.
- FEEDER_DOUBLE_BUF_EN: write B=2*I while streaming B=I -> current stream shows I, the next start streams 2*I.
